iob_uart_fifo_core: RTL

//  Next-generation UART engine behind the iob_uart CPU register file: full-duplex serial TX/RX with

---
 rtl/iob_uart_fifo_core_if.sv | 30 +++
 rtl/iob_uart_fifo_core.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_uart_fifo_core_if.sv
`default_nettype none
// ============================================================================
// Module   : iob_uart_fifo_core_if
// Brief    : CPU-side FIFO port bundle of the UART core (TX push / RX pop).
// Revision : 1.0 - initial release
// ============================================================================
interface iob_uart_fifo_core_if #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_ADDR_W = 4
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_wr;
    logic                 tx_full;
    logic [FIFO_ADDR_W:0] tx_level;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_rd;
    logic                 rx_empty;
    logic [FIFO_ADDR_W:0] rx_level;

    modport master (
        output tx_data, tx_wr, rx_rd,
        input  tx_full, tx_level, rx_data, rx_empty, rx_level
    );

    modport slave (
        input  tx_data, tx_wr, rx_rd,
        output tx_full, tx_level, rx_data, rx_empty, rx_level
    );
endinterface
`default_nettype wire

// File: rtl/iob_uart_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : iob_uart_fifo_core
// Brief    : Full-duplex UART with TX/RX FIFOs, CTS-gated transmit and
//            RTS from RX headroom. Define IOB_UART_PARITY_EN for parity.
// Revision : 1.0 - initial release
// ============================================================================

module iob_uart_fifo_core_sfifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  din,
    input  logic              pop,
    output logic [WIDTH-1:0]  dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);
    localparam int c_depth = 1 << ADDR_W;

    logic [WIDTH-1:0]  r_mem [c_depth];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign empty = (r_level == '0);
    assign full  = (r_level == (ADDR_W+1)'(c_depth));
    assign level = r_level;
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the same cycle pops.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop_ok)      r_level <= r_level + 1'b1;
            else if (!w_push_ok && w_pop_ok) r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) r_mem[r_wr_ptr] <= din;
    end
endmodule

module iob_uart_fifo_core #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_ADDR_W = 4,
    parameter int DIV_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rst_soft,
    input  logic               tx_en,
    input  logic               rx_en,
    input  logic [DIV_W-1:0]   bit_duration,
    iob_uart_fifo_core_if.slave bus,
    output logic               rx_overrun,
    output logic               rx_frame_err,
    output logic               txd,
    input  logic               rxd,
    input  logic               cts,
    output logic               rts
`ifdef IOB_UART_PARITY_EN
    ,
    input  logic               parity_en,
    input  logic               parity_odd,
    output logic               rx_parity_err
`endif
);
    localparam int c_depth = 1 << FIFO_ADDR_W;
    localparam logic [2:0] c_last_bit = 3'(DATA_BITS - 1);
    localparam logic [FIFO_ADDR_W:0] c_rts_lvl = (FIFO_ADDR_W+1)'(c_depth - 2);

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_WAIT   = 3'd5
    } rx_state_t;

    logic                 w_rst;
    logic                 r_rxd_meta, r_rxd_sync;
    logic                 r_cts_meta, r_cts_sync;
    logic [DIV_W-1:0]     w_bd;
    logic [DIV_W-1:0]     w_bd_m1;
    logic [DIV_W-1:0]     w_half_m1;

    tx_state_t            r_tx_state;
    logic [DIV_W-1:0]     r_tx_cnt;
    logic [2:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_sh;
    logic                 r_txd;
    logic [DATA_BITS-1:0] w_tx_head;
    logic                 w_tx_empty;
    logic                 w_tx_pop;

    rx_state_t            r_rx_state;
    logic [DIV_W-1:0]     r_rx_cnt;
    logic [2:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_sh;
    logic                 w_rx_push;
    logic                 w_rx_full;
    logic                 w_rx_empty;
    logic                 r_overrun;
    logic                 r_frame_err;
    logic                 r_rts;

    assign w_rst = rst | rst_soft;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_cts_meta <= 1'b0;
            r_cts_sync <= 1'b0;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
            r_cts_meta <= cts;
            r_cts_sync <= r_cts_meta;
        end
    end

    // Divisors below 2 would leave no room for a mid-bit sample.
    assign w_bd      = (bit_duration < DIV_W'(2)) ? DIV_W'(2) : bit_duration;
    assign w_bd_m1   = w_bd - DIV_W'(1);
    assign w_half_m1 = (w_bd >> 1) - DIV_W'(1);

    iob_uart_fifo_core_sfifo #(.WIDTH(DATA_BITS), .ADDR_W(FIFO_ADDR_W)) u_tx_fifo (
        .clk   (clk),
        .rst   (w_rst),
        .push  (bus.tx_wr),
        .din   (bus.tx_data),
        .pop   (w_tx_pop),
        .dout  (w_tx_head),
        .full  (bus.tx_full),
        .empty (w_tx_empty),
        .level (bus.tx_level)
    );

    iob_uart_fifo_core_sfifo #(.WIDTH(DATA_BITS), .ADDR_W(FIFO_ADDR_W)) u_rx_fifo (
        .clk   (clk),
        .rst   (w_rst),
        .push  (w_rx_push),
        .din   (r_rx_sh),
        .pop   (bus.rx_rd),
        .dout  (bus.rx_data),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .level (bus.rx_level)
    );

    assign bus.rx_empty = w_rx_empty;

    // End of a stop bit is a launch point too, so back-to-back frames have no gap.
    assign w_tx_pop = tx_en & ~w_tx_empty & r_cts_sync &
                      ((r_tx_state == TX_IDLE) ||
                       ((r_tx_state == TX_STOP) && (r_tx_cnt == '0)));

`ifdef IOB_UART_PARITY_EN
    logic r_tx_par;
    logic r_tx_par_en;
    logic r_rx_par_err;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_tx_par    <= 1'b0;
            r_tx_par_en <= 1'b0;
        end else if (w_tx_pop) begin
            r_tx_par    <= (^w_tx_head) ^ parity_odd;
            r_tx_par_en <= parity_en;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst)
            r_rx_par_err <= 1'b0;
        else if ((r_rx_state == RX_PARITY) && (r_rx_cnt == '0) &&
                 (r_rxd_sync != ((^r_rx_sh) ^ parity_odd)))
            r_rx_par_err <= 1'b1;
    end

    assign rx_parity_err = r_rx_par_err;
`endif

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_sh    <= '0;
            r_txd      <= 1'b1;
        end else if (r_tx_state == TX_IDLE) begin
            r_txd <= 1'b1;
            if (w_tx_pop) begin
                r_tx_state <= TX_START;
                r_tx_sh    <= w_tx_head;
                r_tx_cnt   <= w_bd_m1;
                r_txd      <= 1'b0;
            end
        end else if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
        end else begin
            r_tx_cnt <= w_bd_m1;
            case (r_tx_state)
                TX_START: begin
                    r_tx_state <= TX_DATA;
                    r_txd      <= r_tx_sh[0];
                    r_tx_sh    <= r_tx_sh >> 1;
                    r_tx_bit   <= '0;
                end
                TX_DATA: begin
                    if (r_tx_bit == c_last_bit) begin
`ifdef IOB_UART_PARITY_EN
                        if (r_tx_par_en) begin
                            r_tx_state <= TX_PARITY;
                            r_txd      <= r_tx_par;
                        end else
`endif
                        begin
                            r_tx_state <= TX_STOP;
                            r_txd      <= 1'b1;
                        end
                    end else begin
                        r_txd    <= r_tx_sh[0];
                        r_tx_sh  <= r_tx_sh >> 1;
                        r_tx_bit <= r_tx_bit + 1'b1;
                    end
                end
                TX_PARITY: begin
                    r_tx_state <= TX_STOP;
                    r_txd      <= 1'b1;
                end
                TX_STOP: begin
                    if (w_tx_pop) begin
                        r_tx_state <= TX_START;
                        r_tx_sh    <= w_tx_head;
                        r_txd      <= 1'b0;
                    end else begin
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_txd      <= 1'b1;
                end
            endcase
        end
    end

    assign txd = r_txd;

    assign w_rx_push = (r_rx_state == RX_STOP) && (r_rx_cnt == '0) && r_rxd_sync;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_sh     <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (r_rx_state == RX_IDLE) begin
            if (rx_en && !r_rxd_sync) begin
                r_rx_state <= RX_START;
                r_rx_cnt   <= w_half_m1;
            end
        end else if (r_rx_state == RX_WAIT) begin
            if (r_rxd_sync) r_rx_state <= RX_IDLE;
        end else if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
        end else begin
            r_rx_cnt <= w_bd_m1;
            case (r_rx_state)
                RX_START: begin
                    r_rx_state <= r_rxd_sync ? RX_IDLE : RX_DATA;
                    r_rx_bit   <= '0;
                end
                RX_DATA: begin
                    r_rx_sh <= {r_rxd_sync, r_rx_sh[DATA_BITS-1:1]};
                    if (r_rx_bit == c_last_bit) begin
`ifdef IOB_UART_PARITY_EN
                        r_rx_state <= parity_en ? RX_PARITY : RX_STOP;
`else
                        r_rx_state <= RX_STOP;
`endif
                    end else begin
                        r_rx_bit <= r_rx_bit + 1'b1;
                    end
                end
                RX_PARITY: r_rx_state <= RX_STOP;
                RX_STOP: begin
                    if (r_rxd_sync) begin
                        r_rx_state <= RX_IDLE;
                        if (w_rx_full && !bus.rx_rd) r_overrun <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_rx_state  <= RX_WAIT;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) r_rts <= 1'b0;
        else       r_rts <= rx_en & (bus.rx_level < c_rts_lvl);
    end

    assign rts          = r_rts;
    assign rx_overrun   = r_overrun;
    assign rx_frame_err = r_frame_err;
endmodule
`default_nettype wire
